dmem_ctrl: RTL

- Load/store sequencer between the pipeline memory stage and the word-wide data memory.
- The data memory has a combinational read and a synchronous write.
- Accepts one load/store request at a time and checks alignment and funct3.
- Performs read-modify-write for byte/halfword stores, extracts and sign/zero-extends load data, and returns a single-cycle response.

---
 rtl/dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store sequencer between the memory stage and a
// word-wide data memory (combinational read, synchronous write).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake (ready only in IDLE)
//   req_we          1 = store, 0 = load
//   req_funct3      RISC-V size/sign field
//   req_addr        byte address
//   req_wdata       store data (low byte/half for SB/SH)
//   resp_valid      one-cycle completion pulse
//   resp_fault      misaligned or illegal funct3
//   resp_rdata      extended load data, 0 for stores and faults
//   mem_addr        word address to data memory
//   mem_we, mem_wd  data-memory write enable / data
//   mem_rd          data-memory read data
//
// Optional build macro DMEM_CTRL_PERF_EN adds the 32-bit counters
// perf_loads, perf_stores, perf_faults and perf_rmw as outputs.

module dmem_ctrl #(
  parameter int MEM_AW     = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_fault,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DMEM_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_loads,
  output logic [31:0]           perf_stores,
  output logic [31:0]           perf_faults,
  output logic [31:0]           perf_rmw
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } st_t;

  st_t st_q;
  st_t st_d;

  logic                  we_q;
  logic [2:0]            f3_q;
  logic [MEM_AW+1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rfault_q;

  // Address bits above the memory window are not used.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:MEM_AW+2];

  // ---------------- request decode ----------------
  logic f3_ok;
  logic mis;
  logic dec_fault;
  logic dec_sw;

  always_comb begin
    f3_ok = 1'b0;
    unique case (req_funct3)
      3'b000,
      3'b001,
      3'b010:  f3_ok = 1'b1;
      3'b100,
      3'b101:  f3_ok = ~req_we;
      default: f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    mis = 1'b0;
    unique case (req_funct3[1:0])
      2'b01:   mis = req_addr[0];
      2'b10:   mis = |req_addr[1:0];
      default: mis = 1'b0;
    endcase
  end

  assign dec_fault = ~f3_ok | mis;
  assign dec_sw    = req_we & (req_funct3 == 3'b010);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_fault)   st_d = RESP;
          else if (dec_sw) st_d = WR;
          else             st_d = RD;
        end
      end
      RD:      st_d = we_q ? WR : RESP;
      WR:      st_d = RESP;
      RESP:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // ---------------- state outputs ----------------
  always_comb begin
    req_ready  = (st_q == IDLE);
    resp_valid = (st_q == RESP);
    // Reset in WR must cancel the write in the same cycle.
    mem_we     = (st_q == WR) & ~rst;
  end

  assign mem_addr   = addr_q[MEM_AW+1:2];
  assign resp_fault = rfault_q;
  assign resp_rdata = rdata_q;

  // ---------------- load extraction ----------------
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    ld_b = mem_rd[7:0];
    unique case (addr_q[1:0])
      2'd0: ld_b = mem_rd[7:0];
      2'd1: ld_b = mem_rd[15:8];
      2'd2: ld_b = mem_rd[23:16];
      2'd3: ld_b = mem_rd[31:24];
    endcase
    ld_h = addr_q[1] ? mem_rd[31:16]
                     : mem_rd[15:0];
  end

  always_comb begin
    ld_data = mem_rd;
    unique case (f3_q)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_data = {24'd0, ld_b};
      3'b101:  ld_data = {16'd0, ld_h};
      default: ld_data = mem_rd;
    endcase
  end

  // ---------------- store merge ----------------
  always_comb begin
    mem_wd = merge_q;
    unique case (1'b1)
      (f3_q[1:0] == 2'b10): mem_wd = wd_q;
      (f3_q[1:0] == 2'b01): begin
        if (addr_q[1]) mem_wd[31:16] = wd_q[15:0];
        else           mem_wd[15:0]  = wd_q[15:0];
      end
      default: begin
        unique case (addr_q[1:0])
          2'd0: mem_wd[7:0]   = wd_q[7:0];
          2'd1: mem_wd[15:8]  = wd_q[7:0];
          2'd2: mem_wd[23:16] = wd_q[7:0];
          2'd3: mem_wd[31:24] = wd_q[7:0];
        endcase
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wd_q     <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      rfault_q <= 1'b0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            f3_q   <= req_funct3;
            addr_q <= req_addr[MEM_AW+1:0];
            wd_q   <= req_wdata;
            if (dec_fault) begin
              rfault_q <= 1'b1;
              rdata_q  <= '0;
            end
          end
        end
        RD: begin
          if (we_q) begin
            merge_q <= mem_rd;
          end else begin
            rdata_q  <= ld_data;
            rfault_q <= 1'b0;
          end
        end
        WR: begin
          rdata_q  <= '0;
          rfault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_CTRL_PERF_EN
  logic is_resp;
  logic is_rmw;

  assign is_resp = (st_q == RESP);
  assign is_rmw  = (st_q == WR) &
                   (f3_q[1:0] != 2'b10);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_faults <= '0;
      perf_rmw    <= '0;
    end else begin
      if (is_resp & ~rfault_q & ~we_q)
        perf_loads <= perf_loads + 32'd1;
      if (is_resp & ~rfault_q & we_q)
        perf_stores <= perf_stores + 32'd1;
      if (is_resp & rfault_q)
        perf_faults <= perf_faults + 32'd1;
      if (is_rmw)
        perf_rmw <= perf_rmw + 32'd1;
    end
  end
`endif

endmodule
